// File: rtl/avaliador_pkg.sv
// avaliador_pkg
// Shared definitions for the move judge (avaliador_jogada):
//   - 3-bit FSM state encodings
//   - MAX_BOTOES: widest button vector the one-hot helper accepts
//   - is_one_hot(): true when exactly one bit of the vector is set
package avaliador_pkg;

  localparam logic [2:0] OCIOSO        = 3'd0;
  localparam logic [2:0] ESPERA_SOLTAR = 3'd1;
  localparam logic [2:0] AGUARDA       = 3'd2;
  localparam logic [2:0] ACERTO        = 3'd3;
  localparam logic [2:0] ERRO          = 3'd4;

  localparam int MAX_BOTOES = 32;

  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  function automatic logic is_one_hot(input logic [MAX_BOTOES-1:0] v);
    logic [MAX_BOTOES-1:0] v_menos_um;
    v_menos_um = v - {{(MAX_BOTOES-1){1'b0}}, 1'b1};
    return (v != '0) && ((v & v_menos_um) == '0);
  endfunction

endpackage

// File: rtl/detector_borda.sv
// detector_borda
// Button history registers and rising-edge vector for the move judge.
// Optional build macro AVALIADOR_SINCRONIZADOR_EN: when defined, botoes
// first passes through a 2-flop synchronizer (reset to 0), adding two
// cycles of latency; when undefined, botoes is taken as synchronous.
// Ports:
//   clock    in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   botoes   in   WIDTH button levels, active-high
//   botoes_q out  WIDTH first history stage (registered levels)
//   borda    out  WIDTH rising edges: botoes_q & ~botoes_q2
module detector_borda #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] botoes,
  output logic [WIDTH-1:0] botoes_q,
  output logic [WIDTH-1:0] borda
);

  logic [WIDTH-1:0] botoes_entrada;
  logic [WIDTH-1:0] botoes_q2;

`ifdef AVALIADOR_SINCRONIZADOR_EN
  logic [WIDTH-1:0] sinc_ff1;
  logic [WIDTH-1:0] sinc_ff2;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sinc_ff1 <= '0;
      sinc_ff2 <= '0;
    end else begin
      sinc_ff1 <= botoes;
      sinc_ff2 <= sinc_ff1;
    end
  end

  assign botoes_entrada = sinc_ff2;
`else
  assign botoes_entrada = botoes;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      botoes_q  <= '0;
      botoes_q2 <= '0;
    end else begin
      botoes_q  <= botoes_entrada;
      botoes_q2 <= botoes_q;
    end
  end

  assign borda = botoes_q & ~botoes_q2;

endmodule

// File: rtl/avaliador_jogada.sv
// avaliador_jogada
// Judges one player move per round and emits a single-cycle acertou or
// errou pulse for the downstream score counter. Pulses are Moore outputs
// and always separated by at least one idle cycle.
// Optional build macro AVALIADOR_SINCRONIZADOR_EN (see detector_borda).
// Ports:
//   clock          in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   enable         in   game running; low forces idle
//   iniciar        in   start-round request, honoured only when idle
//   alvo           in   N_BOTOES one-hot expected button
//   botoes         in   N_BOTOES button levels, active-high
//   acertou        out  one-cycle pulse, correct move
//   errou          out  one-cycle pulse, wrong move or timeout
//   jogando        out  round in progress
//   tempo_restante out  TW remaining cycles of the window, 0 when idle
//
// state         | meaning
// OCIOSO        | idle, waiting for iniciar
// ESPERA_SOLTAR | button held at start, waiting for release; timer frozen
// AGUARDA       | window open, timer counting down
// ACERTO        | one-cycle correct verdict
// ERRO          | one-cycle wrong/timeout verdict
module avaliador_jogada
  import avaliador_pkg::*;
#(
  parameter  int N_BOTOES = 4,
  parameter  int TIMEOUT  = 1000,
  localparam int TW       = $clog2(TIMEOUT + 1)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                iniciar,
  input  logic [N_BOTOES-1:0] alvo,
  input  logic [N_BOTOES-1:0] botoes,
  output logic                acertou,
  output logic                errou,
  output logic                jogando,
  output logic [TW-1:0]       tempo_restante
);

  localparam logic [TW-1:0] CARGA_TEMPO = TW'(TIMEOUT);

  logic [2:0]          state;
  logic [2:0]          state_next;
  logic [TW-1:0]       contador;
  logic [TW-1:0]       contador_next;
  logic [N_BOTOES-1:0] alvo_reg;
  logic [N_BOTOES-1:0] alvo_next;
  logic [N_BOTOES-1:0] botoes_q;
  logic [N_BOTOES-1:0] borda;

  detector_borda #(
    .WIDTH (N_BOTOES)
  ) u_detector_borda (
    .clock    (clock),
    .reset_n  (reset_n),
    .botoes   (botoes),
    .botoes_q (botoes_q),
    .borda    (borda)
  );

  // The counter is forced to 0 outside the two playing states, so it can
  // drive tempo_restante directly.
  always_comb begin
    state_next    = state;
    contador_next = contador;
    alvo_next     = alvo_reg;
    if (!enable) begin
      state_next    = OCIOSO;
      contador_next = '0;
    end else begin
      case (state)
        OCIOSO: begin
          contador_next = '0;
          if (iniciar) begin
            alvo_next = alvo;
            if (!is_one_hot(MAX_BOTOES'(alvo))) begin
              state_next = ERRO;
            end else if (|botoes_q) begin
              // A button already down would otherwise count as an instant answer.
              state_next    = ESPERA_SOLTAR;
              contador_next = CARGA_TEMPO;
            end else begin
              state_next    = AGUARDA;
              contador_next = CARGA_TEMPO;
            end
          end
        end
        ESPERA_SOLTAR: begin
          if (botoes_q == '0) begin
            state_next    = AGUARDA;
            contador_next = CARGA_TEMPO;
          end
        end
        AGUARDA: begin
          // Press edge wins over timeout in the same cycle.
          if (borda != '0) begin
            state_next    = (borda == alvo_reg) ? ACERTO : ERRO;
            contador_next = '0;
          end else if (contador == '0) begin
            state_next = ERRO;
          end else begin
            contador_next = contador - TW'(1);
          end
        end
        ACERTO, ERRO: begin
          state_next    = OCIOSO;
          contador_next = '0;
        end
        default: begin
          state_next    = OCIOSO;
          contador_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= OCIOSO;
      contador <= '0;
      alvo_reg <= '0;
    end else begin
      state    <= state_next;
      contador <= contador_next;
      alvo_reg <= alvo_next;
    end
  end

  assign acertou        = (state == ACERTO);
  assign errou          = (state == ERRO);
  assign jogando        = (state == ESPERA_SOLTAR) || (state == AGUARDA);
  assign tempo_restante = contador;

endmodule

// File: tb/tb_avaliador_jogada.sv
// tb_avaliador_jogada
// Self-checking bench for avaliador_jogada with N_BOTOES=4, TIMEOUT=8.
// Table rows describe single rounds (target, press pattern, press delay,
// expected verdict); hand-written sequences cover held buttons, invalid
// targets, ignored starts, reset/enable aborts and back-to-back rounds.
module tb_avaliador_jogada;

`ifdef AVALIADOR_SINCRONIZADOR_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  localparam int TMO = 8;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic       iniciar;
  logic [3:0] alvo;
  logic [3:0] botoes;
  logic       acertou;
  logic       errou;
  logic       jogando;
  logic [3:0] tempo_restante;

  int checks = 0;
  int errors = 0;

  avaliador_jogada #(
    .N_BOTOES (4),
    .TIMEOUT  (TMO)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .iniciar        (iniciar),
    .alvo           (alvo),
    .botoes         (botoes),
    .acertou        (acertou),
    .errou          (errou),
    .jogando        (jogando),
    .tempo_restante (tempo_restante)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] alvo;
    logic [3:0] botoes;
    int         atraso;
    logic       exp_acertou;
    logic       exp_errou;
  } vetor_t;

  vetor_t tabela [7];

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nome, atual, esperado, $time);
    end
  endtask

  task automatic ciclo();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_saidas(input string nome, input logic ea, input logic ee,
                            input logic ej, input int et);
    chk({nome, " acertou"}, 32'(acertou), 32'(ea));
    chk({nome, " errou"},   32'(errou),   32'(ee));
    chk({nome, " jogando"}, 32'(jogando), 32'(ej));
    chk({nome, " tempo"},   32'(tempo_restante), 32'(et));
  endtask

  // Start a valid round from idle with no button down.
  task automatic inicia(input logic [3:0] a);
    @(negedge clock);
    iniciar = 1'b1;
    alvo    = a;
    ciclo();
    chk_saidas("inicio", 1'b0, 1'b0, 1'b1, TMO);
  endtask

  task automatic espera(input int d);
    for (int i = 1; i <= d; i++) begin
      @(negedge clock);
      iniciar = 1'b0;
      ciclo();
      chk_saidas("janela", 1'b0, 1'b0, 1'b1, TMO - i);
    end
  endtask

  // Drive the press d cycles into AGUARDA and check the verdict timing.
  task automatic fase_press(input logic [3:0] press, input int d,
                            input logic ea, input logic ee);
    @(negedge clock);
    iniciar = 1'b0;
    botoes  = press;
    for (int j = 1; j <= LAT + 2; j++) begin
      ciclo();
      chk("veredito acertou", 32'(acertou), 32'(ea && (j == LAT)));
      chk("veredito errou",   32'(errou),   32'(ee && (j == LAT)));
      chk("veredito jogando", 32'(jogando), 32'(j < LAT));
      if (j < LAT) begin
        int t;
        t = TMO - d - j;
        if (t < 0) t = 0;
        chk("veredito tempo", 32'(tempo_restante), 32'(t));
      end
    end
    @(negedge clock);
    botoes = '0;
    repeat (LAT + 1) ciclo();
  endtask

  initial begin
    tabela[0] = '{4'b0100, 4'b0100, 3,       1'b1, 1'b0};  // correct press
    tabela[1] = '{4'b0010, 4'b1000, 3,       1'b0, 1'b1};  // wrong button
    tabela[2] = '{4'b0010, 4'b0011, 3,       1'b0, 1'b1};  // two buttons same cycle
    tabela[3] = '{4'b0001, 4'b0001, 9 - LAT, 1'b1, 1'b0};  // edge on counter==0
    tabela[4] = '{4'b0001, 4'b0000, 9 - LAT, 1'b0, 1'b1};  // timeout
    tabela[5] = '{4'b1000, 4'b1000, 0,       1'b1, 1'b0};  // immediate press
    tabela[6] = '{4'b0001, 4'b0010, 1,       1'b0, 1'b1};  // wrong, early

    reset_n = 1'b0;
    enable  = 1'b1;
    iniciar = 1'b0;
    alvo    = '0;
    botoes  = '0;
    repeat (3) ciclo();
    chk_saidas("reset", 1'b0, 1'b0, 1'b0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) ciclo();
    chk_saidas("ocioso", 1'b0, 1'b0, 1'b0, 0);

    for (int k = 0; k < 7; k++) begin
      inicia(tabela[k].alvo);
      espera(tabela[k].atraso);
      fase_press(tabela[k].botoes, tabela[k].atraso,
                 tabela[k].exp_acertou, tabela[k].exp_errou);
    end

    // Held button: frozen counter, release, then a fresh press.
    @(negedge clock);
    botoes = 4'b0001;
    repeat (LAT + 1) ciclo();
    inicia(4'b0001);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      iniciar = 1'b0;
      ciclo();
      chk_saidas("segurado", 1'b0, 1'b0, 1'b1, TMO);
    end
    @(negedge clock);
    botoes = '0;
    for (int j = 1; j <= LAT; j++) begin
      ciclo();
      chk_saidas("soltura", 1'b0, 1'b0, 1'b1, TMO);
    end
    ciclo();
    chk_saidas("reabre", 1'b0, 1'b0, 1'b1, TMO - 1);
    fase_press(4'b0001, 1, 1'b1, 1'b0);

    // Invalid targets: zero and multi-bit.
    @(negedge clock);
    iniciar = 1'b1;
    alvo    = 4'b0000;
    ciclo();
    chk_saidas("alvo zero", 1'b0, 1'b1, 1'b0, 0);
    @(negedge clock);
    iniciar = 1'b0;
    ciclo();
    chk_saidas("alvo zero fim", 1'b0, 1'b0, 1'b0, 0);
    @(negedge clock);
    iniciar = 1'b1;
    alvo    = 4'b0110;
    ciclo();
    chk_saidas("alvo duplo", 1'b0, 1'b1, 1'b0, 0);
    @(negedge clock);
    iniciar = 1'b0;
    ciclo();

    // iniciar and alvo changes during AGUARDA are ignored.
    inicia(4'b0100);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clock);
      iniciar = 1'b1;
      alvo    = 4'b1000;
      ciclo();
      chk_saidas("iniciar ignorado", 1'b0, 1'b0, 1'b1, TMO - i);
    end
    fase_press(4'b0100, 2, 1'b1, 1'b0);

    // Asynchronous reset mid-round.
    inicia(4'b0001);
    espera(3);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk_saidas("reset assincrono", 1'b0, 1'b0, 1'b0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    ciclo();
    chk_saidas("pos reset", 1'b0, 1'b0, 1'b0, 0);

    // enable low mid-round.
    inicia(4'b0010);
    espera(2);
    @(negedge clock);
    enable = 1'b0;
    ciclo();
    chk_saidas("enable baixo", 1'b0, 1'b0, 1'b0, 0);
    ciclo();
    chk_saidas("enable baixo 2", 1'b0, 1'b0, 1'b0, 0);
    @(negedge clock);
    enable = 1'b1;
    ciclo();
    chk_saidas("enable volta", 1'b0, 1'b0, 1'b0, 0);

    // Back-to-back rounds with iniciar held: pulses never adjacent.
    @(negedge clock);
    iniciar = 1'b1;
    alvo    = 4'b0000;
    for (int j = 0; j < 6; j++) begin
      ciclo();
      chk("seguidas errou",   32'(errou),   32'((j % 2) == 0));
      chk("seguidas acertou", 32'(acertou), 32'(0));
    end
    @(negedge clock);
    iniciar = 1'b0;
    repeat (2) ciclo();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
